// File: rtl/dual_core_pkg.sv
// Shared definitions for the dual-core partial-sum exchange: default widths,
// queue indices and the TX/RX handshake state encodings.
package dual_core_pkg;

  localparam int BW_PSUM_DEFAULT = 20;
  localparam int XW_DEFAULT      = BW_PSUM_DEFAULT + 4;
  localparam int DEPTH_DEFAULT   = 4;

  // Queue indices inside the controller: pairing, transmit and peer queues.
  localparam int Q_LQ  = 0;
  localparam int Q_TQ  = 1;
  localparam int Q_PQ  = 2;
  localparam int NUM_Q = 3;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_DROP = 2'd2
  } tx_state_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_t;

endpackage

// File: rtl/sum_xchg_ctrl_sync_fifo.sv
// Small synchronous FIFO with a combinational head read, so a consumer can
// pop and use the head word on the same edge.
module sync_fifo #(
  parameter int width = 24,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] full_cnt = (aw + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [aw-1:0]    wr_ptr_reg;
  logic [aw-1:0]    rd_ptr_reg;
  logic [aw:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == full_cnt);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + aw'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + aw'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + (aw + 1)'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - (aw + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/sum_xchg_ctrl.sv
// Exchanges local partial sums with a peer core over two four-phase
// handshakes and emits the in-order signed sum of each local/peer pair.
module sum_xchg_ctrl
  import dual_core_pkg::*;
#(
  parameter int bw_psum = BW_PSUM_DEFAULT,
  parameter int depth   = DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw_psum+3:0] sum_in,
  input  logic               sum_valid,
  output logic               sum_ready,
  output logic [bw_psum+3:0] sum_out,
  output logic               tx_req,
  input  logic               tx_ack,
  input  logic               rx_req,
  output logic               rx_ack,
  input  logic [bw_psum+3:0] tx_sum_in,
  output logic [bw_psum+4:0] total,
  output logic               total_valid,
  output logic               busy
);

  localparam int w = bw_psum + 4;

  logic [NUM_Q-1:0] q_push;
  logic [NUM_Q-1:0] q_pop;
  logic [NUM_Q-1:0] q_full;
  logic [NUM_Q-1:0] q_empty;
  logic [w-1:0]     q_wdata [NUM_Q];
  logic [w-1:0]     q_rdata [NUM_Q];

  tx_state_t    tx_state_reg;
  rx_state_t    rx_state_reg;
  logic [w-1:0] sum_out_reg;
  logic         tx_req_reg;
  logic         rx_ack_reg;
  logic [w:0]   total_reg;
  logic         total_valid_reg;

  logic local_push;
  logic tx_pop;
  logic rx_push;
  logic pair;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_Q; gi++) begin : g_q
      sync_fifo #(.width(w), .depth(depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push[gi]),
        .wdata (q_wdata[gi]),
        .pop   (q_pop[gi]),
        .rdata (q_rdata[gi]),
        .full  (q_full[gi]),
        .empty (q_empty[gi])
      );
    end
  endgenerate

  assign sum_ready  = !reset && !q_full[Q_LQ] && !q_full[Q_TQ];
  assign local_push = sum_valid && sum_ready;
  assign tx_pop     = (tx_state_reg == TX_IDLE) && !q_empty[Q_TQ];
  assign rx_push    = (rx_state_reg == RX_IDLE) && rx_req && !q_full[Q_PQ];
  assign pair       = !q_empty[Q_LQ] && !q_empty[Q_PQ];

  // Each accepted local sum feeds both the pairing and the transmit path.
  assign q_push[Q_LQ]  = local_push;
  assign q_push[Q_TQ]  = local_push;
  assign q_push[Q_PQ]  = rx_push;
  assign q_wdata[Q_LQ] = sum_in;
  assign q_wdata[Q_TQ] = sum_in;
  assign q_wdata[Q_PQ] = tx_sum_in;
  assign q_pop[Q_LQ]   = pair;
  assign q_pop[Q_TQ]   = tx_pop;
  assign q_pop[Q_PQ]   = pair;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg <= TX_IDLE;
      tx_req_reg   <= 1'b0;
      sum_out_reg  <= '0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_pop) begin
            sum_out_reg  <= q_rdata[Q_TQ];
            tx_req_reg   <= 1'b1;
            tx_state_reg <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (tx_ack) begin
            tx_req_reg   <= 1'b0;
            tx_state_reg <= TX_DROP;
          end
        end
        TX_DROP: begin
          if (!tx_ack) tx_state_reg <= TX_IDLE;
        end
        default: begin
          tx_req_reg   <= 1'b0;
          tx_state_reg <= TX_IDLE;
        end
      endcase
    end
  end

  // A full peer queue simply withholds the ack, stalling the peer's word.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      rx_ack_reg   <= 1'b0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (rx_push) begin
            rx_ack_reg   <= 1'b1;
            rx_state_reg <= RX_ACK;
          end
        end
        RX_ACK: begin
          if (!rx_req) begin
            rx_ack_reg   <= 1'b0;
            rx_state_reg <= RX_IDLE;
          end
        end
        default: begin
          rx_ack_reg   <= 1'b0;
          rx_state_reg <= RX_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_reg       <= '0;
      total_valid_reg <= 1'b0;
    end else begin
      total_valid_reg <= pair;
      if (pair) begin
        total_reg <= {q_rdata[Q_LQ][w-1], q_rdata[Q_LQ]} +
                     {q_rdata[Q_PQ][w-1], q_rdata[Q_PQ]};
      end
    end
  end

  assign sum_out     = sum_out_reg;
  assign tx_req      = tx_req_reg;
  assign rx_ack      = rx_ack_reg;
  assign total       = total_reg;
  assign total_valid = total_valid_reg;
  assign busy        = !reset && (!(&q_empty) || (tx_state_reg != TX_IDLE) ||
                                  (rx_state_reg != RX_IDLE));

endmodule

// File: tb/tb_sum_xchg_ctrl.sv
// Directed bench: one controller against a scripted peer, plus two
// cross-connected controllers exchanging a table of sums.
module tb_sum_xchg_ctrl;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b1;

  logic [W-1:0] sum_in = '0;
  logic         sum_valid = 1'b0;
  logic         sum_ready;
  logic [W-1:0] sum_out;
  logic         tx_req;
  logic         tx_ack;
  logic         rx_req = 1'b0;
  logic         rx_ack;
  logic [W-1:0] tx_sum_in = '0;
  logic [W:0]   total;
  logic         total_valid;
  logic         busy;

  logic         auto_ack = 1'b0;
  logic         man_ack = 1'b0;
  logic         ack_auto = 1'b0;

  // Cross-connected pair
  logic [W-1:0] sum_in_a = '0, sum_in_b = '0;
  logic         sum_valid_a = 1'b0, sum_valid_b = 1'b0;
  logic         sum_ready_a, sum_ready_b;
  logic [W-1:0] sum_out_a, sum_out_b;
  logic         tx_req_a, tx_req_b, rx_ack_a, rx_ack_b;
  logic [W:0]   total_a, total_b;
  logic         total_valid_a, total_valid_b, busy_a, busy_b;

  int checks = 0;
  int failures = 0;

  logic [W:0]   got_q[$];
  logic [W-1:0] tx_q[$];
  logic [W:0]   ga[$];
  logic [W:0]   gb[$];
  logic [W-1:0] va[16];
  logic [W-1:0] vb[16];

  always #5 clk = ~clk;

  assign tx_ack = auto_ack ? ack_auto : man_ack;

  sum_xchg_ctrl dut (
    .clk(clk), .reset(reset), .sum_in(sum_in), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .sum_out(sum_out), .tx_req(tx_req), .tx_ack(tx_ack),
    .rx_req(rx_req), .rx_ack(rx_ack), .tx_sum_in(tx_sum_in), .total(total),
    .total_valid(total_valid), .busy(busy)
  );

  sum_xchg_ctrl u_a (
    .clk(clk), .reset(reset), .sum_in(sum_in_a), .sum_valid(sum_valid_a),
    .sum_ready(sum_ready_a), .sum_out(sum_out_a), .tx_req(tx_req_a), .tx_ack(rx_ack_b),
    .rx_req(tx_req_b), .rx_ack(rx_ack_a), .tx_sum_in(sum_out_b), .total(total_a),
    .total_valid(total_valid_a), .busy(busy_a)
  );

  sum_xchg_ctrl u_b (
    .clk(clk), .reset(reset), .sum_in(sum_in_b), .sum_valid(sum_valid_b),
    .sum_ready(sum_ready_b), .sum_out(sum_out_b), .tx_req(tx_req_b), .tx_ack(rx_ack_a),
    .rx_req(tx_req_a), .rx_ack(rx_ack_b), .tx_sum_in(sum_out_a), .total(total_b),
    .total_valid(total_valid_b), .busy(busy_b)
  );

  // Peer that mirrors tx_req back as tx_ack one cycle later.
  always @(posedge clk) begin
    #2;
    ack_auto = tx_req;
  end

  always @(posedge clk) begin
    #1;
    if (total_valid) begin
      got_q.push_back(total);
      $display("dut total=%0h", total);
    end
    if (total_valid_a) ga.push_back(total_a);
    if (total_valid_b) gb.push_back(total_b);
  end

  logic tx_req_prev = 1'b0;
  always @(posedge clk) begin
    #1;
    if (tx_req && !tx_req_prev) begin
      tx_q.push_back(sum_out);
      $display("dut tx word=%0h", sum_out);
    end
    tx_req_prev = tx_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic peer_send(input logic [W-1:0] word, output logic ok);
    int n;
    ok = 1'b1;
    tx_sum_in = word;
    rx_req = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rx_ack && n < 40);
    if (!rx_ack) ok = 1'b0;
    rx_req = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (rx_ack && n < 40);
    if (rx_ack) ok = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic       ok;
    logic [W:0] e;
    bit         acc_a, acc_b, will_a, will_b;

    // Reset state
    repeat (3) tick();
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_rx_ack", 32'(rx_ack), 32'd0);
    chk("rst_total_valid", 32'(total_valid), 32'd0);
    chk("rst_total", 32'(total), 32'd0);
    chk("rst_sum_out", 32'(sum_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum_ready", 32'(sum_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_sum_ready", 32'(sum_ready), 32'd1);

    // 5 + 7 with a manual four-phase transmit handshake
    tick();
    rx_req = 1'b1; tx_sum_in = 24'd7;
    tick();
    chk("b1_rx_ack_hi", 32'(rx_ack), 32'd1);
    rx_req = 1'b0;
    tick();
    chk("b1_rx_ack_lo", 32'(rx_ack), 32'd0);
    sum_in = 24'd5; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    chk("b1_tv_early", 32'(total_valid), 32'd0);
    tick();
    chk("b1_tv", 32'(total_valid), 32'd1);
    chk("b1_total", 32'(total), 32'd12);
    chk("b1_tx_req_hi", 32'(tx_req), 32'd1);
    chk("b1_sum_out", 32'(sum_out), 32'd5);
    tick();
    chk("b1_tv_pulse", 32'(total_valid), 32'd0);
    chk("b1_total_hold", 32'(total), 32'd12);
    chk("b1_tx_req_wait", 32'(tx_req), 32'd1);
    man_ack = 1'b1;
    tick();
    chk("b1_tx_req_drop", 32'(tx_req), 32'd0);
    chk("b1_busy_drop", 32'(busy), 32'd1);
    man_ack = 1'b0;
    tick();
    chk("b1_busy_idle", 32'(busy), 32'd0);

    // Signed: -3 + -1
    auto_ack = 1'b1;
    sum_in = 24'hFFFFFD; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    rx_req = 1'b1; tx_sum_in = 24'hFFFFFF;
    tick();
    rx_req = 1'b0;
    tick();
    chk("b2_tv", 32'(total_valid), 32'd1);
    chk("b2_total", 32'(total), 32'h1FFFFFC);
    for (int i = 0; i < 40 && rx_ack; i++) tick();
    drain("b2_drain");

    // Peer backpressure with a full PQ
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      peer_send(24'(10 + i), ok);
      chk($sformatf("b3_ack%0d", i), 32'(ok), 32'd1);
    end
    rx_req = 1'b1; tx_sum_in = 24'd14;
    repeat (5) tick();
    chk("b3_ack_held_low", 32'(rx_ack), 32'd0);
    chk("b3_busy", 32'(busy), 32'd1);
    sum_in = 24'd100; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    tick();
    chk("b3_tv", 32'(total_valid), 32'd1);
    chk("b3_total", 32'(total), 32'd110);
    chk("b3_ack_not_yet", 32'(rx_ack), 32'd0);
    tick();
    chk("b3_fifth_ack", 32'(rx_ack), 32'd1);
    rx_req = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b3_ready%0d", i), 32'(sum_ready), 32'd1);
      sum_in = 24'(101 + i); sum_valid = 1'b1;
      tick();
    end
    sum_valid = 1'b0;
    drain("b3_drain");
    chk("b3_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("b3_tot%0d", i), 32'(got_q[i]), 32'(110 + 2 * i));

    // Local stall with tx_ack held low
    got_q.delete();
    tx_q.delete();
    auto_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b4_ready%0d", i), 32'(sum_ready), 32'd1);
      sum_in = 24'(1 + i); sum_valid = 1'b1;
      tick();
    end
    chk("b4_ready_drop", 32'(sum_ready), 32'd0);
    sum_in = 24'd5;
    repeat (3) tick();
    chk("b4_still_stalled", 32'(sum_ready), 32'd0);
    sum_valid = 1'b0;
    chk("b4_tx_req", 32'(tx_req), 32'd1);
    chk("b4_sum_out", 32'(sum_out), 32'd1);
    auto_ack = 1'b1;
    peer_send(24'd21, ok);
    chk("b4_peer0", 32'(ok), 32'd1);
    chk("b4_ready_back", 32'(sum_ready), 32'd1);
    sum_in = 24'd5; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      peer_send(24'(21 + i), ok);
      chk($sformatf("b4_peer%0d", i), 32'(ok), 32'd1);
    end
    drain("b4_drain");
    chk("b4_tot_count", 32'(got_q.size()), 32'd5);
    chk("b4_tx_count", 32'(tx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("b4_tot%0d", i), 32'(got_q[i]), 32'(22 + 2 * i));
    for (int i = 0; i < 5 && i < tx_q.size(); i++)
      chk($sformatf("b4_tx%0d", i), 32'(tx_q[i]), 32'(1 + i));

    // Reset while TX sits in REQ
    auto_ack = 1'b0;
    sum_in = 24'd9; sum_valid = 1'b1;
    tick();
    sum_valid = 1'b0;
    tick();
    chk("b5_tx_req", 32'(tx_req), 32'd1);
    reset = 1'b1;
    tick();
    chk("b5_tx_req_rst", 32'(tx_req), 32'd0);
    chk("b5_busy_rst", 32'(busy), 32'd0);
    chk("b5_ready_rst", 32'(sum_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("b5_ready_after", 32'(sum_ready), 32'd1);
    chk("b5_busy_after", 32'(busy), 32'd0);
    auto_ack = 1'b1;
    tick();

    // Two cross-connected controllers
    va[0] = 24'h7FFFFF; vb[0] = 24'h7FFFFF;
    va[1] = 24'h800000; vb[1] = 24'h800000;
    for (int k = 2; k < 16; k++) begin
      va[k] = 24'($urandom);
      vb[k] = 24'($urandom);
    end
    ga.delete();
    gb.delete();
    for (int k = 0; k < 16; k++) begin
      sum_in_a = va[k]; sum_valid_a = 1'b1; acc_a = 1'b0;
      sum_in_b = vb[k]; sum_valid_b = 1'b1; acc_b = 1'b0;
      for (int n = 0; n < 200 && !(acc_a && acc_b); n++) begin
        will_a = sum_valid_a && sum_ready_a;
        will_b = sum_valid_b && sum_ready_b;
        tick();
        if (will_a) begin acc_a = 1'b1; sum_valid_a = 1'b0; end
        if (will_b) begin acc_b = 1'b1; sum_valid_b = 1'b0; end
      end
      chk($sformatf("b6_accept%0d", k), 32'({acc_a, acc_b}), 32'd3);
      sum_valid_a = 1'b0;
      sum_valid_b = 1'b0;
    end
    for (int i = 0; i < 400 && (busy_a || busy_b); i++) tick();
    chk("b6_idle", 32'({busy_a, busy_b}), 32'd0);
    chk("b6_count_a", 32'(ga.size()), 32'd16);
    chk("b6_count_b", 32'(gb.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      e = {va[k][W-1], va[k]} + {vb[k][W-1], vb[k]};
      if (k < ga.size()) chk($sformatf("b6_a%0d", k), 32'(ga[k]), 32'(e));
      if (k < gb.size()) chk($sformatf("b6_b%0d", k), 32'(gb[k]), 32'(e));
    end
    chk("b6_ext_max", 32'(ga.size() > 0 ? ga[0] : '0), 32'h0FFFFFE);
    chk("b6_ext_min", 32'(ga.size() > 1 ? ga[1] : '0), 32'h1000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
